// File: rtl/seg16_readback.sv
// Decodes a snapshot of the four active-low 16-segment digit words back to ASCII; optional CR/LF frame trailer under SEG16_READBACK_CRLF_EN.
// Latency: snap at posedge N gives ascii_valid after posedge N+2; sustained rate is one byte per 2 cycles.
// Backpressure: each byte holds on ascii_out/ascii_valid/last until accepted; snaps while busy are dropped and counted in overrun.
module seg16_readback #(
    parameter int          OVR_W        = 8,
    parameter logic [7:0]  UNKNOWN_CHAR = 8'h3F
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      LEDa,
    input  logic [15:0]      LEDb,
    input  logic [15:0]      LEDc,
    input  logic [15:0]      LEDd,
    input  logic             snap,
    output logic [7:0]       ascii_out,
    output logic             ascii_valid,
    input  logic             ascii_ready,
    output logic             last,
    output logic             busy,
    output logic [OVR_W-1:0] overrun
);

`ifdef SEG16_READBACK_CRLF_EN
    localparam int               IDX_W    = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = 3'd5;
`else
    localparam int               IDX_W    = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = 2'd3;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        EMIT = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [15:0]      cap   [4];
    logic [15:0]      led_q [4];
    logic             snap_q;
    logic             fin_q;
    logic [7:0]       next_byte;

    function automatic logic [7:0] seg_decode(input logic [15:0] w);
        logic [7:0] c;
        case (w)
            16'hFFFF: c = 8'h20;
            16'hF17D: c = 8'h61;
            16'hEDFA: c = 8'h77;
            16'h767D: c = 8'h73;
            16'hFC7D: c = 8'h68;
            16'hF57E: c = 8'h65;
            16'h0000: c = 8'h2A;
            default:  c = UNKNOWN_CHAR;
        endcase
        return c;
    endfunction

    always_comb begin
        next_byte = seg_decode(cap[idx[1:0]]);
`ifdef SEG16_READBACK_CRLF_EN
        if (idx == 3'd4) begin
            next_byte = 8'h0D;
        end else if (idx == 3'd5) begin
            next_byte = 8'h0A;
        end
`endif
    end

    // snap and the LED buses are retimed together, so the captured words
    // are the ones present on the edge where snap was seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            ascii_out   <= 8'h00;
            ascii_valid <= 1'b0;
            last        <= 1'b0;
            busy        <= 1'b0;
            overrun     <= '0;
            snap_q      <= 1'b0;
            fin_q       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cap[i]   <= 16'hFFFF;
                led_q[i] <= 16'hFFFF;
            end
        end else begin
            snap_q   <= snap;
            led_q[0] <= LEDa;
            led_q[1] <= LEDb;
            led_q[2] <= LEDc;
            led_q[3] <= LEDd;
            fin_q    <= 1'b0;

            // fin_q marks a snap that arrived with the final handshake
            if (snap_q && (state != IDLE || fin_q) && overrun != '1) begin
                overrun <= overrun + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (snap_q && !fin_q) begin
                        for (int i = 0; i < 4; i++) begin
                            cap[i] <= led_q[i];
                        end
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    ascii_out   <= next_byte;
                    ascii_valid <= 1'b1;
                    last        <= (idx == LAST_IDX);
                    state       <= EMIT;
                end
                EMIT: begin
                    if (ascii_ready) begin
                        ascii_valid <= 1'b0;
                        if (last) begin
                            last  <= 1'b0;
                            busy  <= 1'b0;
                            fin_q <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= CAPT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seg16_readback.md
Name: seg16_readback

Overview:
- Decoder counterpart to the ASCII-to-segment character ROM that feeds the four-digit 16-segment scrolling marquee.
- On a snapshot strobe, captures the four active-low segment words currently driven to digits a..d.
- Decodes each word back to an ASCII byte and streams the bytes, digit a first, over a valid/ready byte interface.
- Sits beside the marquee driver, taps its LED buses, and feeds a debug/host byte sink.

Parameters:
- OVR_W, 8, width of the saturating snapshot-overrun counter.
- UNKNOWN_CHAR, 8'h3F, ASCII byte emitted for any segment word not in the decode table.

Ports:
- clk  input  1  system clock, from the on-chip oscillator.
- rst_n  input  1  asynchronous, active-low reset.
- LEDa  input  16  digit a segment word, active-low (1 = segment off).
- LEDb  input  16  digit b segment word.
- LEDc  input  16  digit c segment word.
- LEDd  input  16  digit d segment word.
- snap  input  1  one-cycle request to capture LEDa..LEDd.
- ascii_out  output  8  decoded ASCII byte.
- ascii_valid  output  1  ascii_out is valid.
- ascii_ready  input  1  sink accepts the byte when ascii_valid && ascii_ready at a posedge.
- last  output  1  marks the final byte of a frame; qualified by ascii_valid.
- busy  output  1  high from capture until the final byte is accepted.
- overrun  output  OVR_W  count of snap pulses ignored while busy; saturating.

Behaviour:
- Reset (asynchronous, rst_n low):
  - ascii_out = 8'h00; ascii_valid, last and busy = 0; overrun = 0.
  - Capture registers = 16'hFFFF; state = IDLE.
  - Reset asserted mid-frame aborts the frame immediately; no further bytes are emitted after release.
- States: IDLE, CAPT, EMIT, WAIT.
  - IDLE: snap=1 latches LEDa..LEDd into cap[0..3], sets idx=0 and busy=1, and moves to CAPT.
  - CAPT: decodes cap[idx] into the ascii_out register, asserts ascii_valid, sets last=(idx==final index), and moves to EMIT.
  - EMIT: ascii_out, ascii_valid and last hold stable until handshake.
    - On handshake when not last: idx+1, ascii_valid=0, next state CAPT. There is one bubble cycle between bytes.
    - On handshake when last: ascii_valid=0, last=0, busy=0, next state IDLE.
  - WAIT: reserved; decodes to IDLE.
- Latency: snap at posedge N; ascii_valid high after posedge N+2.
- Decode table (exact 16-bit match, active-low):
  - FFFF -> 0x20 (space)
  - F17D -> 'a'
  - EDFA -> 'w'
  - 767D -> 's'
  - FC7D -> 'h'
  - F57E -> 'e'
  - 0000 -> 0x2A ('*', all segments lit)
  - anything else -> UNKNOWN_CHAR
- snap handling:
  - snap while busy is ignored and increments overrun, which saturates at all-ones.
  - snap in the same cycle as the final handshake is also ignored and counted. A new frame needs snap in IDLE.
- Captured values are frozen for the frame. LED inputs changing mid-frame do not affect emitted bytes.
- ascii_ready may be held high continuously; the sustained rate is one byte per 2 cycles.
- ascii_ready high while ascii_valid is low has no effect.

Optional Feature:
- Macro: SEG16_READBACK_CRLF_EN.
- Defined:
  - Each frame is 6 bytes: four decoded chars, then 0x0D, then 0x0A.
  - last is asserted only with 0x0A; idx runs 0..5, and indices 4 and 5 bypass the decode table.
- Undefined:
  - Each frame is 4 bytes, and last is asserted with the digit d byte.
  - No CR/LF logic is present.

Test Plan:
- Reset/idle: hold rst_n=0 with LED buses = 0x1234 -> all outputs at reset values; after release with no snap, ascii_valid stays 0 for 100 cycles.
- Basic frame: LEDa..d = F17D, EDFA, F17D, 767D, ascii_ready=1, snap at cycle N -> bytes 'a','w','a','s' on alternate cycles, first valid after posedge N+2, last with 's', busy drops after the 's' handshake. With CRLF_EN, the frame continues with 0D, 0A and last moves to 0A.
- Backpressure: same frame with ascii_ready low for 5 cycles on each byte -> ascii_out, ascii_valid and last stable while stalled; no byte dropped or duplicated.
- Unknown/blank/all-on: LEDa..d = FFFF, 0000, 1234, FC7D -> 0x20, 0x2A, 0x3F, 'h'.
- Overrun: 3 snap pulses during a stalled frame, then 300 more -> overrun = 3, then saturates at 255; the frame content is unchanged. A snap coincident with the final handshake is counted, and no second frame starts.
- Mid-frame reset and input change:
  - Change LED buses after capture -> emitted bytes match the captured values.
  - Assert rst_n=0 during the second byte -> ascii_valid drops asynchronously; no bytes after release until the next snap.
